prng_arbiter: RTL
=================

Name: prng_arbiter

Overview:
- Shares a single prng instance (32-bit, `next`-strobed) among N requesters using round-robin arbitration.
- Sequences the PRNG's reset/seed load at power-up and on runtime reseed requests.
- Delivers each generated word, registered, to exactly one requester with a one-cycle valid pulse.
- Sits between the prng and peripheral/CPU-side consumers in the peripherals subsystem.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SEED_DEFAULT, 32'hdeadbeef, seed loaded at power-up.
- RST_CYCLES, 2, cycles prng_rst is held high per seed load (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester request level; held until that requester's valid pulse.
- valid  output  N_REQ  one-hot, one-cycle pulse; rand_out is for that requester.
- rand_out  output  32  registered random word.
- reseed_req  input  1  single-cycle strobe; reseed with reseed_val.
- reseed_val  input  32  seed sampled when reseed_req=1.
- busy  output  1  high in any state other than IDLE.
- prng_rst  output  1  active-high reset to prng.
- prng_seed  output  32  seed to prng; held stable while prng_rst=1.
- prng_next  output  1  advance strobe to prng.
- prng_num  input  32  prng output; updates one clk after prng_next is sampled.

Behaviour:
- Reset values while rst=0:
  - state=INIT, prng_rst=1, prng_seed=SEED_DEFAULT.
  - prng_next=0, valid=0, rand_out=0, rr_ptr=0, busy=1, cnt=0, reseed_pend=0.
- State machine:
  - INIT: hold prng_rst=1 for RST_CYCLES clocks after rst deasserts, counted by cnt. On the last cycle, deassert prng_rst at the next edge and go to IDLE.
  - IDLE:
    - If reseed_pend=1 or reseed_req=1: load prng_seed, go to INIT. Reseed has priority over req.
    - Else if req!=0: choose winner = first set bit at or above rr_ptr, wrapping modulo N_REQ. Register winner, assert prng_next for one cycle, go to ISSUE.
  - ISSUE: prng_next=0. Go to CAPTURE.
  - CAPTURE:
    - rand_out<=prng_num; valid[winner]<=1 for one cycle.
    - rr_ptr<=(winner+1) mod N_REQ; go to GAP.
  - GAP: one idle cycle, matching the PRNG's minimum next spacing of 2 clocks. Go to IDLE.
- Throughput and latency:
  - One word per 4 clocks.
  - Latency from req rising (IDLE) to valid is 3 clocks.
- Requester sampling:
  - req is sampled only in IDLE.
  - A requester that drops req before grant is simply not chosen.
  - A requester holding req after valid competes again; round-robin guarantees the others are served first.
- Reseed:
  - reseed_req in any non-IDLE state sets reseed_pend and captures reseed_val; the latest strobe wins.
  - The reseed takes effect at the next IDLE. An in-flight word completes delivery first.
  - Entering INIT from IDLE clears reseed_pend and restarts cnt.
- Seed and output stability:
  - prng_seed changes only on entry to INIT.
  - rand_out holds its value between deliveries.
- Reset mid-operation: async return to reset values. Any in-flight word is discarded and no valid is emitted.
- Simultaneous reseed_req and req in IDLE: reseed wins; req is served after INIT.
- N_REQ=1: rr_ptr stays 0.

Decomposition:
- Shared package prng_pkg holds:
  - the state encoding (INIT, IDLE, ISSUE, CAPTURE, GAP);
  - PRNG_W=32.
- One natural sub-module: rr_pick, a combinational round-robin priority picker taking (req, rr_ptr) and returning (winner index, any).

Test Plan:
- Power-up: release rst. Expect prng_rst=1 for 2 clocks, prng_seed=32'hdeadbeef, busy=0 at the 3rd clock, no valid.
- Single requester: req=4'b0001 held. Expect valid=0001 at 3 clocks, then every 4 clocks. rand_out matches the prng golden sequence from seed deadbeef.
- Fairness: req=4'b1111 from rr_ptr=0. Expect valid order 0001, 0010, 0100, 1000, 0001, each 4 clocks apart.
- Skip and wrap: rr_ptr=2 after a prior grant to requester 1, req=4'b0011. Expect grant to 0 then 1.
- Reseed mid-word: reseed_req with reseed_val=32'h12345678 during ISSUE.
  - The current word is delivered with valid.
  - Then INIT with prng_seed=12345678 and prng_rst high for 2 clocks.
  - The next word equals the first golden word for seed 12345678.
- Async reset in CAPTURE: drop rst. Expect valid=0, rand_out=0, prng_rst=1 immediately, with no stray valid after release.

Source files
------------

// File: rtl/prng_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg : shared types and constants for the PRNG arbiter slice
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package prng_pkg;

  localparam int PRNG_W = 32;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  // Index width that stays legal (>=1 bit) even for a single entry.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prng_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first set bit at/above ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int j;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    winner = '0;
    j      = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) winner = IDX_W'(j);
    end
    any = |req;
  end

endmodule

`default_nettype wire

// File: rtl/prng_arbiter.sv
// ---------------------------------------------------------------------------
// prng_arbiter : shares one next-strobed PRNG among N_REQ requesters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prng_arbiter
  import prng_pkg::*;
#(
  parameter int                N_REQ        = 4,
  parameter logic [PRNG_W-1:0] SEED_DEFAULT = 32'hdeadbeef,
  parameter int                RST_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  valid,
  output logic [PRNG_W-1:0] rand_out,
  input  logic              reseed_req,
  input  logic [PRNG_W-1:0] reseed_val,
  output logic              busy,
  output logic              prng_rst,
  output logic [PRNG_W-1:0] prng_seed,
  output logic              prng_next,
  input  logic [PRNG_W-1:0] prng_num
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = idx_w(RST_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prng_rst_q, prng_rst_d;
  logic [PRNG_W-1:0]   prng_seed_q, prng_seed_d;
  logic                prng_next_q, prng_next_d;
  logic [N_REQ-1:0]    valid_q, valid_d;
  logic [PRNG_W-1:0]   rand_out_q, rand_out_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic                busy_q, busy_d;
  logic                reseed_pend_q, reseed_pend_d;
  logic [PRNG_W-1:0]   pend_seed_q, pend_seed_d;

  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    prng_rst_d    = prng_rst_q;
    prng_seed_d   = prng_seed_q;
    prng_next_d   = 1'b0;
    valid_d       = '0;
    rand_out_d    = rand_out_q;
    rr_ptr_d      = rr_ptr_q;
    winner_d      = winner_q;
    reseed_pend_d = reseed_pend_q;
    pend_seed_d   = pend_seed_q;

    // Outside IDLE a reseed is parked; the most recent strobe wins.
    if (state_q != ST_IDLE && reseed_req) begin
      reseed_pend_d = 1'b1;
      pend_seed_d   = reseed_val;
    end

    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          prng_rst_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (reseed_pend_q || reseed_req) begin
          prng_seed_d   = reseed_req ? reseed_val : pend_seed_q;
          reseed_pend_d = 1'b0;
          cnt_d         = '0;
          prng_rst_d    = 1'b1;
          state_d       = ST_INIT;
        end else if (pick_any) begin
          winner_d    = pick_idx;
          prng_next_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        rand_out_d = prng_num;
        for (int i = 0; i < N_REQ; i++) valid_d[i] = (winner_q == IDX_W'(i));
        rr_ptr_d = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
        state_d  = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      prng_rst_q    <= 1'b1;
      prng_seed_q   <= SEED_DEFAULT;
      prng_next_q   <= 1'b0;
      valid_q       <= '0;
      rand_out_q    <= '0;
      rr_ptr_q      <= '0;
      winner_q      <= '0;
      busy_q        <= 1'b1;
      reseed_pend_q <= 1'b0;
      pend_seed_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prng_rst_q    <= prng_rst_d;
      prng_seed_q   <= prng_seed_d;
      prng_next_q   <= prng_next_d;
      valid_q       <= valid_d;
      rand_out_q    <= rand_out_d;
      rr_ptr_q      <= rr_ptr_d;
      winner_q      <= winner_d;
      busy_q        <= busy_d;
      reseed_pend_q <= reseed_pend_d;
      pend_seed_q   <= pend_seed_d;
    end
  end

  assign valid     = valid_q;
  assign rand_out  = rand_out_q;
  assign busy      = busy_q;
  assign prng_rst  = prng_rst_q;
  assign prng_seed = prng_seed_q;
  assign prng_next = prng_next_q;

endmodule

`default_nettype wire
